axil_sram_slave: RTL and testbench

AXI-lite slave memory sitting directly downstream of the 2x1 AXI-lite arbiter; it consumes the arbiter's merged master port (aw/w/b/ar/r) and serves IFU/LSU traffic from an internal word array. Independent read and write FSMs, parameterised access latency, address range decode with DECERR. Used as the simulation main memory behind the arbiter.

---
 rtl/axil_sram_slave_pkg.sv | 25 ++
 rtl/axil_sram_slave_if.sv | 36 +++
 rtl/axil_sram_array.sv | 30 +++
 rtl/axil_sram_slave.sv | 219 +++++++++++++++++++++
 tb/tb_axil_sram_slave.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_sram_slave_pkg.sv
// Shared definitions for the AXI-lite SRAM slave: response codes, FSM states, LFSR step.
package axil_sram_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_WAIT = 2'b01,
        W_RESP = 2'b10
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_WAIT = 2'b01,
        R_DATA = 2'b10
    } r_state_e;

    // Fibonacci step for x^8+x^6+x^5+x^4+1
    function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/axil_sram_slave_if.sv
// AXI-lite channel bundle (aw/w/b/ar/r) between the arbiter master port and the SRAM slave.
interface axil_sram_slave_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axil_sram_array.sv
// Word array with one byte-strobed synchronous write port and one asynchronous read port; never reset.
module axil_sram_array #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4096,
    localparam int STRB_W    = DATA_WIDTH / 8,
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [STRB_W-1:0]     i_wstrb,
    input  logic [IDX_W-1:0]      i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // byte-lane write; a same-edge read of this word still sees the old contents
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/axil_sram_slave.sv
// AXI-lite SRAM slave: independent read/write FSMs, LATENCY wait cycles, DECERR outside the window.
// Build option AXIL_SRAM_RAND_DELAY_EN adds 0-3 LFSR-chosen wait cycles to every request.
module axil_sram_slave
    import axil_sram_slave_pkg::*;
#(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
    parameter int                    DEPTH      = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    LATENCY    = 1
) (
    input logic              i_aclk,
    input logic              i_arsetn,
    axil_sram_slave_if.slave bus
);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int IDX_LSB = $clog2(STRB_WIDTH);
    localparam int CNT_W   = $clog2(LATENCY + 4) + 1;
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(DEPTH * STRB_WIDTH);

    w_state_e              r_wstate, w_wstate_nxt;
    r_state_e              r_rstate, w_rstate_nxt;
    logic                  r_aw_got, r_w_got, r_bvalid, r_rvalid;
    logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr, w_woff, w_roff;
    logic [DATA_WIDTH-1:0] r_wdata, r_rdata, w_rd_data;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic [CNT_W-1:0]      r_wcnt, r_rcnt, w_delay;
    logic [1:0]            r_bresp, r_rresp, w_extra;
    logic                  w_awready, w_wready, w_arready, w_aw_hs, w_w_hs, w_ar_hs;
    logic                  w_wcommit, w_bdone, w_rsample, w_rdone, w_win_range, w_rin_range;
    logic                  w_unused;

    assign w_woff      = r_awaddr - BASE_ADDR;
    assign w_roff      = r_araddr - BASE_ADDR;
    assign w_win_range = (r_awaddr >= BASE_ADDR) && ({1'b0, w_woff} < SPAN);
    assign w_rin_range = (r_araddr >= BASE_ADDR) && ({1'b0, w_roff} < SPAN);
    assign w_unused    = ^{bus.awprot, bus.arprot};

`ifdef AXIL_SRAM_RAND_DELAY_EN
    logic [7:0] r_lfsr;

    // free-running delay source, stepped every cycle
    always_ff @(posedge i_aclk or negedge i_arsetn) begin
        if (!i_arsetn) r_lfsr <= 8'hA5;
        else           r_lfsr <= lfsr8_next(r_lfsr);
    end
    assign w_extra = r_lfsr[1:0];
`else
    assign w_extra = 2'd0;
`endif
    assign w_delay = CNT_W'(LATENCY) + CNT_W'(w_extra);

    // write FSM: next state, readies, commit and response-done strobes
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_awready    = 1'b0;
        w_wready     = 1'b0;
        w_wcommit    = 1'b0;
        w_bdone      = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                w_awready = ~r_aw_got;
                w_wready  = ~r_w_got;
                if ((r_aw_got | bus.awvalid) & (r_w_got | bus.wvalid)) w_wstate_nxt = W_WAIT;
                else                                                    w_wstate_nxt = W_IDLE;
            end
            W_WAIT: begin
                if (r_wcnt == '0) begin
                    w_wcommit    = 1'b1;
                    w_wstate_nxt = W_RESP;
                end else begin
                    w_wstate_nxt = W_WAIT;
                end
            end
            W_RESP: begin
                if (bus.bready) begin
                    w_bdone      = 1'b1;
                    w_wstate_nxt = W_IDLE;
                end else begin
                    w_wstate_nxt = W_RESP;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    assign w_aw_hs = bus.awvalid & w_awready;
    assign w_w_hs  = bus.wvalid & w_wready;

    // write FSM state register
    always_ff @(posedge i_aclk or negedge i_arsetn) begin
        if (!i_arsetn) r_wstate <= W_IDLE;
        else           r_wstate <= w_wstate_nxt;
    end

    // write capture, wait counter and response registers
    always_ff @(posedge i_aclk or negedge i_arsetn) begin
        if (!i_arsetn) begin
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_wcnt   <= '0;
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_aw_got <= 1'b1;
                r_awaddr <= bus.awaddr;
            end else if (w_bdone) begin
                r_aw_got <= 1'b0;
            end
            if (w_w_hs) begin
                r_w_got <= 1'b1;
                r_wdata <= bus.wdata;
                r_wstrb <= bus.wstrb;
            end else if (w_bdone) begin
                r_w_got <= 1'b0;
            end
            if (r_wstate == W_IDLE && w_wstate_nxt == W_WAIT) r_wcnt <= w_delay;
            else if (r_wstate == W_WAIT && r_wcnt != '0)      r_wcnt <= r_wcnt - CNT_W'(1);
            if (w_wcommit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_win_range ? RESP_OKAY : RESP_DECERR;
            end else if (w_bdone) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // read FSM: next state, arready, sample and data-done strobes
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_arready    = 1'b0;
        w_rsample    = 1'b0;
        w_rdone      = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                w_arready = 1'b1;
                if (bus.arvalid) w_rstate_nxt = R_WAIT;
                else             w_rstate_nxt = R_IDLE;
            end
            R_WAIT: begin
                if (r_rcnt == '0) begin
                    w_rsample    = 1'b1;
                    w_rstate_nxt = R_DATA;
                end else begin
                    w_rstate_nxt = R_WAIT;
                end
            end
            R_DATA: begin
                if (bus.rready) begin
                    w_rdone      = 1'b1;
                    w_rstate_nxt = R_IDLE;
                end else begin
                    w_rstate_nxt = R_DATA;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    assign w_ar_hs = bus.arvalid & w_arready;

    // read FSM state register
    always_ff @(posedge i_aclk or negedge i_arsetn) begin
        if (!i_arsetn) r_rstate <= R_IDLE;
        else           r_rstate <= w_rstate_nxt;
    end

    // read address capture, wait counter and data/response registers
    always_ff @(posedge i_aclk or negedge i_arsetn) begin
        if (!i_arsetn) begin
            r_araddr <= '0;
            r_rcnt   <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            if (w_ar_hs) begin
                r_araddr <= bus.araddr;
                r_rcnt   <= w_delay;
            end else if (r_rstate == R_WAIT && r_rcnt != '0) begin
                r_rcnt <= r_rcnt - CNT_W'(1);
            end
            if (w_rsample) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rin_range ? w_rd_data : '0;
                r_rresp  <= w_rin_range ? RESP_OKAY : RESP_DECERR;
            end else if (w_rdone) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    axil_sram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .i_clk   (i_aclk),
        .i_we    (w_wcommit & w_win_range),
        .i_waddr (w_woff[IDX_LSB +: IDX_W]),
        .i_wdata (r_wdata),
        .i_wstrb (r_wstrb),
        .i_raddr (w_roff[IDX_LSB +: IDX_W]),
        .o_rdata (w_rd_data)
    );

    assign bus.awready = w_awready;
    assign bus.wready  = w_wready;
    assign bus.bvalid  = r_bvalid;
    assign bus.bresp   = r_bresp;
    assign bus.arready = w_arready;
    assign bus.rvalid  = r_rvalid;
    assign bus.rdata   = r_rdata;
    assign bus.rresp   = r_rresp;
endmodule

// File: tb/tb_axil_sram_slave.sv
// Randomized bench for axil_sram_slave against an associative-array memory model.
module tb_axil_sram_slave;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam logic [31:0] SPAN_B = 32'h0000_8000;
    localparam int          LAT    = 1;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  DECERR = 2'b11;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [63:0] model [int];

    always #5 clk = ~clk;

    axil_sram_slave_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus ();

    axil_sram_slave #(
        .DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH(4096), .BASE_ADDR(BASE), .LATENCY(LAT)
    ) dut (
        .i_aclk   (clk),
        .i_arsetn (rst_n),
        .bus      (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < SPAN_B);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 3);
    endfunction

    function automatic logic [63:0] model_read(input logic [31:0] a);
        if (in_range(a) && model.exists(widx(a))) return model[widx(a)];
        return 64'h0;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] w;
        if (!in_range(a)) return;
        w = model_read(a);
        for (int b = 0; b < 8; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        model[widx(a)] = w;
    endfunction

    function automatic logic [31:0] pick_addr(input bit oor);
        logic [31:0] w;
        w = 32'($urandom_range(0, 15)) << 3;
        if (!oor) return BASE + w + 32'($urandom_range(0, 7));
        case ($urandom_range(0, 2))
            0:       return BASE - 32'd8 - w;
            1:       return BASE + SPAN_B + w;
            default: return 32'h0000_1000 + w;
        endcase
    endfunction

    task automatic check_lat(input string tag, input int lat);
`ifdef AXIL_SRAM_RAND_DELAY_EN
        check(tag, 64'(lat >= LAT + 1 && lat <= LAT + 4), 64'd1);
`else
        check(tag, 64'(lat), 64'(LAT + 1));
`endif
    endtask

    // w_lead > 0: W leads AW by w_lead cycles; w_lead < 0: AW leads W
    task automatic axi_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                             input int w_lead, input int b_stall, input logic [1:0] exp_resp);
        int cyc = 0;
        int lat = 0;
        int aw_wait = (w_lead > 0) ? w_lead : 0;
        int w_wait  = (w_lead < 0) ? -w_lead : 0;
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit aw_fire, w_fire;
        bus.awaddr = addr; bus.awprot = 3'($urandom); bus.wdata = data; bus.wstrb = strb; bus.bready = 1'b0;
        while (!(aw_done && w_done) && cyc < 50) begin
            bus.awvalid = !aw_done && (cyc >= aw_wait);
            bus.wvalid  = !w_done && (cyc >= w_wait);
            aw_fire = bus.awvalid && bus.awready;
            w_fire  = bus.wvalid && bus.wready;
            @(posedge clk); #1;
            aw_done = aw_done || aw_fire;
            w_done  = w_done || w_fire;
            if (aw_done && !w_done) check("awready_drop", 64'(bus.awready), 64'd0);
            if (w_done && !aw_done) check("wready_drop", 64'(bus.wready), 64'd0);
            cyc++;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("aw_w_accept", 64'(aw_done && w_done), 64'd1);
        while (!bus.bvalid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check_lat("b_latency", lat);
        check("bresp", 64'(bus.bresp), 64'(exp_resp));
        for (int i = 0; i < b_stall; i++) begin
            @(posedge clk); #1;
            check("bvalid_hold", 64'(bus.bvalid), 64'd1);
            check("bresp_hold", 64'(bus.bresp), 64'(exp_resp));
            check("aw_w_ready_resp", 64'({bus.awready, bus.wready}), 64'd0);
        end
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
        check("bvalid_drop", 64'(bus.bvalid), 64'd0);
        check("aw_w_ready_idle", 64'({bus.awready, bus.wready}), 64'd3);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int r_stall,
                            input logic [63:0] exp_data, input logic [1:0] exp_resp);
        int cyc = 0;
        int lat = 0;
        bit fired = 1'b0;
        bus.araddr = addr; bus.arprot = 3'($urandom); bus.arvalid = 1'b1; bus.rready = 1'b0;
        while (!fired && cyc < 50) begin
            fired = bus.arready;
            @(posedge clk); #1;
            cyc++;
        end
        bus.arvalid = 1'b0;
        check("ar_accept", 64'(fired), 64'd1);
        while (!bus.rvalid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check_lat("r_latency", lat);
        check("rdata", bus.rdata, exp_data);
        check("rresp", 64'(bus.rresp), 64'(exp_resp));
        for (int i = 0; i < r_stall; i++) begin
            @(posedge clk); #1;
            check("rvalid_hold", 64'(bus.rvalid), 64'd1);
            check("rdata_hold", bus.rdata, exp_data);
            check("rresp_hold", 64'(bus.rresp), 64'(exp_resp));
            check("arready_busy", 64'(bus.arready), 64'd0);
        end
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
        check("rvalid_drop", 64'(bus.rvalid), 64'd0);
        check("rdata_keep", bus.rdata, exp_data);
        check("arready_idle", 64'(bus.arready), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, ra, wa;
        logic [63:0] d, old;
        logic [7:0]  s;
        int          wi, ri;
        rst_n = 1'b0;
        bus.awvalid = 1'b0; bus.awaddr = 32'h0; bus.awprot = 3'd0;
        bus.wvalid = 1'b0; bus.wdata = 64'h0; bus.wstrb = 8'h0; bus.bready = 1'b0;
        bus.arvalid = 1'b0; bus.araddr = 32'h0; bus.arprot = 3'd0; bus.rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bvalid", 64'(bus.bvalid), 64'd0);
        check("rst_rvalid", 64'(bus.rvalid), 64'd0);
        check("rst_rdata", bus.rdata, 64'd0);
        check("rst_bresp", 64'(bus.bresp), 64'd0);
        check("rst_rresp", 64'(bus.rresp), 64'd0);
        check("rst_awready", 64'(bus.awready), 64'd1);
        check("rst_wready", 64'(bus.wready), 64'd1);
        check("rst_arready", 64'(bus.arready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        axi_write(BASE, 64'h1122_3344_5566_7788, 8'hFF, 0, 0, OKAY);
        model_write(BASE, 64'h1122_3344_5566_7788, 8'hFF);
        axi_read(BASE, 0, 64'h1122_3344_5566_7788, OKAY);

        axi_write(BASE, 64'hFFFF_FFFF_AAAA_BBBB, 8'h0F, 3, 0, OKAY);
        model_write(BASE, 64'hFFFF_FFFF_AAAA_BBBB, 8'h0F);
        axi_read(BASE, 0, 64'h1122_3344_AAAA_BBBB, OKAY);

        axi_read(32'h7FFF_FFF8, 0, 64'h0, DECERR);
        axi_write(32'h8000_8000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, -2, 0, DECERR);
        axi_read(BASE, 0, 64'h1122_3344_AAAA_BBBB, OKAY);

        axi_write(BASE + 32'd8, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 5, OKAY);
        model_write(BASE + 32'd8, 64'h0123_4567_89AB_CDEF, 8'hFF);
        axi_read(BASE + 32'd8, 5, 64'h0123_4567_89AB_CDEF, OKAY);

`ifndef AXIL_SRAM_RAND_DELAY_EN
        // write commit and read sample land on the same edge for the same word
        fork
            axi_write(BASE + 32'd8, 64'hCAFE_F00D_0BAD_BEEF, 8'hFF, 0, 0, OKAY);
            axi_read(BASE + 32'd8, 0, 64'h0123_4567_89AB_CDEF, OKAY);
        join
        model_write(BASE + 32'd8, 64'hCAFE_F00D_0BAD_BEEF, 8'hFF);
        axi_read(BASE + 32'd8, 0, 64'hCAFE_F00D_0BAD_BEEF, OKAY);
`endif

        bus.araddr = BASE;
        bus.arvalid = 1'b1;
        check("rw_arready", 64'(bus.arready), 64'd1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rw_rst_rvalid", 64'(bus.rvalid), 64'd0);
        check("rw_rst_arready", 64'(bus.arready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rw_rst_rvalid_hold", 64'(bus.rvalid), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        axi_read(BASE, 0, model_read(BASE), OKAY);

        for (int i = 2; i < 16; i++) begin
            a = BASE + 32'(i * 8);
            d = {$urandom, $urandom};
            axi_write(a, d, 8'hFF, 0, 0, OKAY);
            model_write(a, d, 8'hFF);
        end

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    a = pick_addr($urandom_range(0, 5) == 0);
                    d = {$urandom, $urandom};
                    s = 8'($urandom);
                    axi_write(a, d, s, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)),
                              in_range(a) ? OKAY : DECERR);
                    model_write(a, d, s);
                end
                1: begin
                    a = pick_addr($urandom_range(0, 5) == 0);
                    axi_read(a, int'($urandom_range(0, 3)), model_read(a), in_range(a) ? OKAY : DECERR);
                end
                default: begin
                    wi = int'($urandom_range(0, 15));
                    ri = (wi + int'($urandom_range(1, 15))) % 16;
                    wa = BASE + 32'(wi * 8);
                    ra = BASE + 32'(ri * 8);
                    d = {$urandom, $urandom};
                    s = 8'($urandom);
                    old = model_read(ra);
                    fork
                        axi_write(wa, d, s, int'($urandom_range(0, 4)) - 2, 0, OKAY);
                        axi_read(ra, int'($urandom_range(0, 2)), old, OKAY);
                    join
                    model_write(wa, d, s);
                end
            endcase
        end

        for (int i = 0; i < 16; i++) begin
            a = BASE + 32'(i * 8);
            axi_read(a, 0, model_read(a), OKAY);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
